remote_cmd_tx: RTL and testbench
================================

// Module: remote_cmd_tx
// PURPOSE
//  Remote-control command transmitter feeding the Segway's UART command input.
//  Sits between the bench/remote-control command source (cmd, send_cmd) and the DUT's RX pin.
//  Queues 8-bit commands in a small FIFO so the source can fire and continue (non-blocking).
//  Serializes each command as an 8N1 UART frame on TX.
//  Pulses cmd_sent when each frame's stop bit completes.
// PARAMETERS
//  BAUD_DIV    2604  clocks per UART bit (50 MHz / 19200 baud); legal range >= 4
//  FIFO_DEPTH  4     command queue entries; power of 2, >= 2
// PORTS
//  clk        in   1  system clock
//  RST_n      in   1  synchronous active-low reset
//  cmd        in   8  command byte, sampled on send_cmd rising edge
//  send_cmd   in   1  request; level may be held for many cycles, only the 0->1 edge counts
//  TX         out  1  UART serial out, idles high
//  cmd_sent   out  1  one-clk pulse at end of each frame's stop bit
//  tx_busy    out  1  high while a frame is on the line (start bit through stop bit)
//  fifo_full  out  1  queue holds FIFO_DEPTH entries
//  overflow   out  1  one-clk pulse when a send_cmd edge is dropped because the queue is full
// BEHAVIOUR
//  - Reset (RST_n low at posedge clk):
//    TX=1, cmd_sent=0, tx_busy=0, fifo_full=0, overflow=0.
//    FIFO emptied, FSM to IDLE, send_cmd edge register cleared to 0.
//    Reset mid-frame aborts the frame; TX returns high the next clock.
//  - Edge detect: push = send_cmd & ~send_cmd_q, with send_cmd_q registered.
//    send_cmd already high on the first clock after reset counts as one edge.
//  - Push writes cmd into the FIFO at the tail.
//  - Push while full and no pop in the same clock: entry dropped, overflow pulses.
//  - Push and pop in the same clock while full: the push is accepted.
//  - FSM states and transitions:
//    IDLE: if FIFO non-empty, pop the head into a 10-bit shift register {1,data,0}; go to SHIFT.
//    SHIFT: TX = shreg[0]. Baud counter counts 0..BAUD_DIV-1; on wrap, shift right and increment
//      bit_cnt. After bit_cnt reaches 10: pulse cmd_sent, go to IDLE.
//  - Data is sent LSB first. Each bit lasts exactly BAUD_DIV clocks.
//  - Frame length is 10*BAUD_DIV clocks (11*BAUD_DIV with TX_PARITY_EN).
//  - Latency: send_cmd edge sampled at clock N into an empty queue -> TX low from clock N+2.
//  - Back-to-back frames: IDLE is always visited for exactly 1 clock, so TX is high >= 1 clk
//    between stop and start.
//  - tx_busy is high in SHIFT only. It is low in the IDLE cycle, including the cmd_sent cycle.
//  - Counters: the baud counter is ceil(log2(BAUD_DIV)) bits. Occupancy is log2(FIFO_DEPTH)+1 bits.
//    Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  TX_PARITY_EN defined:
//    An even-parity bit (^data) is inserted between data bit 7 and the stop bit.
//    The shift register is 11 bits; cmd_sent fires after bit_cnt reaches 11.
//  TX_PARITY_EN undefined: plain 8N1 as above; no parity logic is synthesized.
// TESTING
//  - Reset with send_cmd=0: TX=1, tx_busy=0, no cmd_sent for 50000 clocks.
//  - send_cmd edge with cmd=8'h47 (BAUD_DIV=16):
//    TX low at clock N+2, then bits 1,1,1,0,0,0,1,0, then 1.
//    cmd_sent pulses once 160 clocks after the start bit begins.
//  - send_cmd held high 500 clocks with cmd=8'hA5: exactly one frame and one cmd_sent pulse.
//  - 4 quick edges (8'h01..8'h04) then a 5th (8'h05) while the first frame is still shifting:
//    all 5 frames are sent in order; no overflow.
//  - 6 edges with the first frame in progress (FIFO_DEPTH=4): the 6th edge pulses overflow and
//    is never sent. fifo_full is high during the 6th edge.
//  - RST_n low mid-data-bit: TX=1 on the next clock, no cmd_sent, queue empty.
//    The next edge (cmd=8'hC3) sends cleanly.
//    With TX_PARITY_EN, 8'h47 carries parity bit 0 and 8'h07 carries parity bit 1.

Source files
------------

// File: rtl/remote_cmd_tx_if.sv
// remote_cmd_tx_if: command-source <-> UART transmitter bundle (cmd, send_cmd in; TX, cmd_sent, tx_busy, fifo_full, overflow out)
interface remote_cmd_tx_if;
  logic [7:0] cmd;
  logic send_cmd;
  logic TX;
  logic cmd_sent;
  logic tx_busy;
  logic fifo_full;
  logic overflow;
  modport master(output cmd, send_cmd, input TX, cmd_sent, tx_busy, fifo_full, overflow);
  modport slave(input cmd, send_cmd, output TX, cmd_sent, tx_busy, fifo_full, overflow);
endinterface

// File: rtl/remote_cmd_tx.sv
// remote_cmd_tx: queued 8N1 UART command transmitter; ports clk, RST_n (sync active-low), bus (slave modport); TX_PARITY_EN adds an even-parity bit
module remote_cmd_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic RST_n,
  remote_cmd_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
`ifdef TX_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic sq, tx, busy, sent, ovf;
  logic [FW-2:0] sh;
  logic [CW-1:0] bc;
  logic [3:0] bits;
  logic push, pop, full, wr;
  logic [FW-2:0] frame;
  assign push = bus.send_cmd & ~sq;
  assign pop = state == IDLE && cnt != '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign wr = push && (!full || pop);
  // Bits after the start bit; the start bit itself goes straight into tx on pop.
`ifdef TX_PARITY_EN
  assign frame = {1'b1, ^mem[rp], mem[rp]};
`else
  assign frame = {1'b1, mem[rp]};
`endif
  assign bus.TX = tx;
  assign bus.cmd_sent = sent;
  assign bus.tx_busy = busy;
  assign bus.fifo_full = full;
  assign bus.overflow = ovf;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= bus.cmd;
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      state <= IDLE;
      sq <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      sh <= '1;
      bc <= '0;
      bits <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      sent <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sq <= bus.send_cmd;
      ovf <= push && full && !pop;
      sent <= 1'b0;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (state == IDLE) begin
        if (pop) begin
          sh <= frame;
          tx <= 1'b0;
          busy <= 1'b1;
          bc <= '0;
          bits <= '0;
          state <= SHIFT;
        end
      end else if (bc == CW'(BAUD_DIV - 1)) begin
        bc <= '0;
        sh <= {1'b1, sh[FW-2:1]};
        if (bits == 4'(FW - 1)) begin
          state <= IDLE;
          tx <= 1'b1;
          busy <= 1'b0;
          sent <= 1'b1;
        end else begin
          bits <= bits + 4'd1;
          tx <= sh[0];
        end
      end else begin
        bc <= bc + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_remote_cmd_tx.sv
// tb_remote_cmd_tx: self-checking bench for remote_cmd_tx with a line-decoding monitor and an expected-byte queue
module tb_remote_cmd_tx;
`ifdef TX_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif
  logic clk = 0;
  logic RST_n;
  int checks = 0, errors = 0;
  int n_sent = 0, n_ovf = 0, n_low = 0, rst_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  remote_cmd_tx_if bus();
  remote_cmd_tx #(.BAUD_DIV(16), .FIFO_DEPTH(4)) dut(.clk(clk), .RST_n(RST_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  always @(negedge clk) begin
    if (bus.cmd_sent === 1'b1) n_sent++;
    if (bus.overflow === 1'b1) n_ovf++;
    if (bus.TX === 1'b0) n_low++;
    if (RST_n === 1'b0) rst_cnt++;
  end
  // Decodes each frame from the line: samples mid-bit, 16 clocks per bit.
  initial begin : monitor
    logic [FW-1:0] s;
    logic b1, c1, b2, c2;
    int r0;
    forever begin
      @(negedge clk);
      if (RST_n === 1'b1 && bus.TX === 1'b0) begin
        r0 = rst_cnt;
        repeat (8) @(negedge clk);
        for (int i = 0; i < FW; i++) begin
          s[i] = bus.TX;
          if (i < FW - 1) repeat (16) @(negedge clk);
        end
        repeat (7) @(negedge clk);
        b1 = bus.tx_busy;
        c1 = bus.cmd_sent;
        @(negedge clk);
        b2 = bus.tx_busy;
        c2 = bus.cmd_sent;
        if (rst_cnt == r0) begin
          check("start_bit", 32'(s[0]), 32'h0);
          check("stop_bit", 32'(s[FW-1]), 32'h1);
`ifdef TX_PARITY_EN
          check("parity_bit", 32'(s[9]), 32'(^s[8:1]));
`endif
          check("busy_before_end", 32'(b1), 32'h1);
          check("sent_before_end", 32'(c1), 32'h0);
          check("busy_at_end", 32'(b2), 32'h0);
          check("sent_at_end", 32'(c2), 32'h1);
          got_q.push_back(s[8:1]);
        end
      end
    end
  end
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.cmd = b;
    bus.send_cmd = 1'b1;
    @(negedge clk);
    bus.send_cmd = 1'b0;
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 200 * (exp_q.size() + 1)) begin
      @(negedge clk);
      t++;
    end
    repeat (200) @(negedge clk);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int s0, o0, l0, n;
    logic [7:0] b;
    RST_n = 1'b0;
    bus.send_cmd = 1'b0;
    bus.cmd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.TX), 32'h1);
    check("rst_busy", 32'(bus.tx_busy), 32'h0);
    check("rst_full", 32'(bus.fifo_full), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);
    check("rst_sent", 32'(bus.cmd_sent), 32'h0);
    RST_n = 1'b1;
    s0 = n_sent;
    l0 = n_low;
    repeat (50000) @(negedge clk);
    check("idle_sent", n_sent - s0, 0);
    check("idle_low", n_low - l0, 0);
    check("idle_busy", 32'(bus.tx_busy), 32'h0);
    s0 = n_sent;
    @(negedge clk);
    bus.cmd = 8'h47;
    bus.send_cmd = 1'b1;
    @(posedge clk);
    #1 check("lat_edge_tx", 32'(bus.TX), 32'h1);
    @(posedge clk);
    #1 check("lat_start_tx", 32'(bus.TX), 32'h0);
    check("lat_busy", 32'(bus.tx_busy), 32'h1);
    @(negedge clk);
    bus.send_cmd = 1'b0;
    exp_q.push_back(8'h47);
    drain("h47");
    check("h47_sent", n_sent - s0, 1);
    s0 = n_sent;
    @(negedge clk);
    bus.cmd = 8'hA5;
    bus.send_cmd = 1'b1;
    repeat (500) @(negedge clk);
    bus.send_cmd = 1'b0;
    exp_q.push_back(8'hA5);
    drain("held");
    check("held_sent", n_sent - s0, 1);
    o0 = n_ovf;
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    repeat (20) @(negedge clk);
    push(8'h05);
    exp_q.push_back(8'h05);
    drain("five");
    check("five_ovf", n_ovf - o0, 0);
    o0 = n_ovf;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    bus.cmd = 8'h15;
    bus.send_cmd = 1'b1;
    check("ovf_full", 32'(bus.fifo_full), 32'h1);
    @(negedge clk);
    check("ovf_pulse", 32'(bus.overflow), 32'h1);
    bus.send_cmd = 1'b0;
    drain("ovf");
    check("ovf_count", n_ovf - o0, 1);
    o0 = n_ovf;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push(b);
        exp_q.push_back(b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain($sformatf("rand%0d", r));
    end
    check("rand_ovf", n_ovf - o0, 0);
`ifdef TX_PARITY_EN
    push(8'h47);
    exp_q.push_back(8'h47);
    push(8'h07);
    exp_q.push_back(8'h07);
    drain("parity");
`endif
    push(8'h5A);
    push(8'h66);
    repeat (40) @(negedge clk);
    RST_n = 1'b0;
    @(posedge clk);
    #1 check("midrst_tx", 32'(bus.TX), 32'h1);
    check("midrst_busy", 32'(bus.tx_busy), 32'h0);
    check("midrst_full", 32'(bus.fifo_full), 32'h0);
    @(negedge clk);
    RST_n = 1'b1;
    s0 = n_sent;
    l0 = n_low;
    repeat (200) @(negedge clk);
    check("midrst_sent", n_sent - s0, 0);
    check("midrst_low", n_low - l0, 0);
    check("midrst_got", got_q.size(), 0);
    got_q.delete();
    push(8'hC3);
    exp_q.push_back(8'hC3);
    drain("c3");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
